// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a circular FIFO feeding a frame serialiser that
// sends start, data (LSB first), optional parity and stop bits back-to-back.
module uart_tx_buffered #(
    parameter int CLK_FREQ        = 19200,
    parameter int BAUDRATE        = 9600,
    parameter int DATA_WIDTH      = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [DATA_WIDTH-1:0]      data,
    output logic                       full,
    output logic                       empty,
    output logic [FIFO_ADDR_WIDTH:0]   level,
    output logic                       overflow,
    output logic                       line,
    output logic                       busy
);

    localparam int DIV    = CLK_FREQ / BAUDRATE;
    localparam int DEPTH  = 2 ** FIFO_ADDR_WIDTH;
    localparam int LW     = FIFO_ADDR_WIDTH + 1;
    localparam int BAUD_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(DIV - 1);
    localparam logic [3:0]        DATA_LAST  = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]        STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic              ODD_PARITY = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_WIDTH-1:0]      mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]              level_q, level_d;
    logic                       full_q, full_d;
    logic                       empty_q, empty_d;
    logic                       overflow_q, overflow_d;
    logic                       push;
    logic                       pop;
    logic [DATA_WIDTH-1:0]      head;

    state_t                     state_q, state_d;
    logic [BAUD_W-1:0]          baud_q, baud_d;
    logic [3:0]                 bit_q, bit_d;
    logic [DATA_WIDTH-1:0]      shift_q, shift_d;
    logic                       parity_q, parity_d;
    logic                       line_q, line_d;
    logic                       baud_last;

    // A push is taken only when there is room; a pop on the same edge does not free a slot in time.
    assign push = wr && !full_q;
    assign head = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= data;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | (wr & full_q);
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_ADDR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    assign baud_last = (baud_q == BAUD_LAST);

    // line_d carries the level of the bit period that begins on this edge.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + BAUD_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        line_d   = line_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                line_d = 1'b1;
                if (!empty_q) begin
                    pop      = 1'b1;
                    shift_d  = head;
                    parity_d = (^head) ^ ODD_PARITY;
                    state_d  = S_START;
                    line_d   = 1'b0;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    line_d  = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            line_d  = parity_q;
                        end else begin
                            state_d = S_STOP;
                            line_d  = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = shift_q >> 1;
                        line_d  = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                    bit_d   = '0;
                    line_d  = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next start bit when more words are waiting.
                        if (!empty_q) begin
                            pop      = 1'b1;
                            shift_d  = head;
                            parity_d = (^head) ^ ODD_PARITY;
                            state_d  = S_START;
                            line_d   = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            line_d  = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                line_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            line_q     <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            line_q     <= line_d;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign line     = line_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: five parameterisations with DIV=4,
// line sampled on every falling clock edge against hand-built frame patterns.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_v;
    logic [7:0] data_v;
    int         sel;
    int         checks = 0;
    int         errors = 0;
    bit         exp_bits[$];

    always #5 clk = ~clk;

    logic       wr0, wr1, wr2, wr3, wr4;
    logic       full0, full1, full2, full3, full4;
    logic       empty0, empty1, empty2, empty3, empty4;
    logic [4:0] level0, level1, level2, level3, level4;
    logic       ovf0, ovf1, ovf2, ovf3, ovf4;
    logic       line0, line1, line2, line3, line4;
    logic       busy0, busy1, busy2, busy3, busy4;
    logic [4:0] data4;

    assign wr0   = wr_v && (sel == 0);
    assign wr1   = wr_v && (sel == 1);
    assign wr2   = wr_v && (sel == 2);
    assign wr3   = wr_v && (sel == 3);
    assign wr4   = wr_v && (sel == 4);
    assign data4 = data_v[4:0];

    uart_tx_buffered #(.CLK_FREQ(38400), .BAUDRATE(9600), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1), .FIFO_ADDR_WIDTH(4)) u0 (
        .clk(clk), .rst(rst), .wr(wr0), .data(data_v), .full(full0), .empty(empty0),
        .level(level0), .overflow(ovf0), .line(line0), .busy(busy0));
    uart_tx_buffered #(.CLK_FREQ(38400), .BAUDRATE(9600), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1), .FIFO_ADDR_WIDTH(4)) u1 (
        .clk(clk), .rst(rst), .wr(wr1), .data(data_v), .full(full1), .empty(empty1),
        .level(level1), .overflow(ovf1), .line(line1), .busy(busy1));
    uart_tx_buffered #(.CLK_FREQ(38400), .BAUDRATE(9600), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1), .FIFO_ADDR_WIDTH(4)) u2 (
        .clk(clk), .rst(rst), .wr(wr2), .data(data_v), .full(full2), .empty(empty2),
        .level(level2), .overflow(ovf2), .line(line2), .busy(busy2));
    uart_tx_buffered #(.CLK_FREQ(38400), .BAUDRATE(9600), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(2), .FIFO_ADDR_WIDTH(4)) u3 (
        .clk(clk), .rst(rst), .wr(wr3), .data(data_v), .full(full3), .empty(empty3),
        .level(level3), .overflow(ovf3), .line(line3), .busy(busy3));
    uart_tx_buffered #(.CLK_FREQ(38400), .BAUDRATE(9600), .DATA_WIDTH(5), .PARITY(1), .STOP_BITS(1), .FIFO_ADDR_WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .wr(wr4), .data(data4), .full(full4), .empty(empty4),
        .level(level4), .overflow(ovf4), .line(line4), .busy(busy4));

    logic       line_m, busy_m, full_m, empty_m, ovf_m;
    logic [4:0] level_m;

    always_comb begin
        line_m = line0; busy_m = busy0; full_m = full0; empty_m = empty0; ovf_m = ovf0; level_m = level0;
        case (sel)
            1: begin line_m = line1; busy_m = busy1; full_m = full1; empty_m = empty1; ovf_m = ovf1; level_m = level1; end
            2: begin line_m = line2; busy_m = busy2; full_m = full2; empty_m = empty2; ovf_m = ovf2; level_m = level2; end
            3: begin line_m = line3; busy_m = busy3; full_m = full3; empty_m = empty3; ovf_m = ovf3; level_m = level3; end
            4: begin line_m = line4; busy_m = busy4; full_m = full4; empty_m = empty4; ovf_m = ovf4; level_m = level4; end
            default: ;
        endcase
    end

    task automatic test_reset();
        rst = 1'b1; wr_v = 1'b0; data_v = 8'h00;
        for (int k = 0; k < 5; k++) begin
            sel = k;
            #1;
            checks++; if (line_m !== 1'b1)     begin errors++; $display("FAIL reset_line inst%0d got %b want 1", k, line_m); end
            checks++; if (busy_m !== 1'b0)     begin errors++; $display("FAIL reset_busy inst%0d got %b want 0", k, busy_m); end
            checks++; if (empty_m !== 1'b1)    begin errors++; $display("FAIL reset_empty inst%0d got %b want 1", k, empty_m); end
            checks++; if (full_m !== 1'b0)     begin errors++; $display("FAIL reset_full inst%0d got %b want 0", k, full_m); end
            checks++; if (level_m !== 5'd0)    begin errors++; $display("FAIL reset_level inst%0d got %0d want 0", k, level_m); end
            checks++; if (ovf_m !== 1'b0)      begin errors++; $display("FAIL reset_overflow inst%0d got %b want 0", k, ovf_m); end
        end
        sel = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    // Push `val` at edge 1 on instance `k`, expect the hand-built frame in exp_bits.
    task automatic test_single_frame(input int k, input logic [7:0] val, input string name);
        int busy_cnt;
        int total;
        int idx;
        logic el, eb;
        sel = k;
        busy_cnt = 0;
        total = 2 + 4 * exp_bits.size() + 8;
        @(negedge clk);
        wr_v = 1'b1; data_v = val;
        for (int n = 1; n <= total; n++) begin
            @(negedge clk);
            wr_v = 1'b0;
            idx = n - 2;
            eb = (idx >= 0) && (idx < 4 * exp_bits.size());
            el = eb ? exp_bits[idx / 4] : 1'b1;
            if (busy_m === 1'b1) busy_cnt++;
            checks++; if (line_m !== el) begin errors++; $display("FAIL %s_line cycle %0d got %b want %b", name, n, line_m, el); end
            checks++; if (busy_m !== eb) begin errors++; $display("FAIL %s_busy cycle %0d got %b want %b", name, n, busy_m, eb); end
            if (n == 1) begin
                checks++; if (empty_m !== 1'b0) begin errors++; $display("FAIL %s_empty_after_push got %b want 0", name, empty_m); end
            end
            if (n == 2) begin
                checks++; if (empty_m !== 1'b1) begin errors++; $display("FAIL %s_empty_after_pop got %b want 1", name, empty_m); end
            end
        end
        checks++;
        if (busy_cnt != 4 * exp_bits.size()) begin
            errors++; $display("FAIL %s_busy_cycles got %0d want %0d", name, busy_cnt, 4 * exp_bits.size());
        end
        $display("%s done: data=%h frame_cycles=%0d checks=%0d errors=%0d", name, val, 4 * exp_bits.size(), checks, errors);
    endtask

    task automatic test_no_parity();
        logic [9:0] fr;
        fr = {1'b1, 8'h55, 1'b0};
        exp_bits.delete();
        for (int i = 0; i < 10; i++) exp_bits.push_back(fr[i]);
        test_single_frame(0, 8'h55, "single_0x55");
    endtask

    task automatic test_parity();
        logic [10:0] fr;
        fr = {1'b1, 1'b1, 8'h07, 1'b0};
        exp_bits.delete();
        for (int i = 0; i < 11; i++) exp_bits.push_back(fr[i]);
        test_single_frame(1, 8'h07, "even_parity_0x07");
        fr = {1'b1, 1'b0, 8'h07, 1'b0};
        exp_bits.delete();
        for (int i = 0; i < 11; i++) exp_bits.push_back(fr[i]);
        test_single_frame(2, 8'h07, "odd_parity_0x07");
    endtask

    task automatic test_narrow();
        logic [7:0] fr;
        fr = {1'b1, 1'b1, 5'h1F, 1'b0};
        exp_bits.delete();
        for (int i = 0; i < 8; i++) exp_bits.push_back(fr[i]);
        test_single_frame(4, 8'hFF, "narrow_0x1F");
    endtask

    task automatic test_back_to_back();
        logic [10:0] fa, fb;
        int busy_cnt;
        int total;
        int idx;
        logic el, eb;
        sel = 3;
        fa = {2'b11, 8'hA3, 1'b0};
        fb = {2'b11, 8'h3C, 1'b0};
        exp_bits.delete();
        for (int i = 0; i < 11; i++) exp_bits.push_back(fa[i]);
        for (int i = 0; i < 11; i++) exp_bits.push_back(fb[i]);
        busy_cnt = 0;
        total = 2 + 88 + 8;
        @(negedge clk);
        wr_v = 1'b1; data_v = 8'hA3;
        for (int n = 1; n <= total; n++) begin
            @(negedge clk);
            wr_v = (n == 1);
            data_v = 8'h3C;
            idx = n - 2;
            eb = (idx >= 0) && (idx < 88);
            el = eb ? exp_bits[idx / 4] : 1'b1;
            if (busy_m === 1'b1) busy_cnt++;
            checks++; if (line_m !== el) begin errors++; $display("FAIL two_stop_line cycle %0d got %b want %b", n, line_m, el); end
            checks++; if (busy_m !== eb) begin errors++; $display("FAIL two_stop_busy cycle %0d got %b want %b", n, busy_m, eb); end
        end
        checks++;
        if (busy_cnt != 88) begin errors++; $display("FAIL two_stop_busy_cycles got %0d want 88", busy_cnt); end
        $display("test_back_to_back done: frames A3,3C checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_fill_overflow();
        logic [9:0] fr;
        int total;
        int idx;
        logic el, eb;
        sel = 0;
        exp_bits.delete();
        for (int f = 0; f < 17; f++) begin
            fr = {1'b1, 8'(f), 1'b0};
            for (int i = 0; i < 10; i++) exp_bits.push_back(fr[i]);
        end
        total = 2 + 4 * exp_bits.size() + 10;
        @(negedge clk);
        wr_v = 1'b1; data_v = 8'h00;
        for (int n = 1; n <= total; n++) begin
            @(negedge clk);
            wr_v = (n < 18);
            data_v = 8'(n);
            idx = n - 2;
            eb = (idx >= 0) && (idx < 4 * exp_bits.size());
            el = eb ? exp_bits[idx / 4] : 1'b1;
            checks++; if (line_m !== el) begin errors++; $display("FAIL fill_line cycle %0d got %b want %b", n, line_m, el); end
            checks++; if (busy_m !== eb) begin errors++; $display("FAIL fill_busy cycle %0d got %b want %b", n, busy_m, eb); end
            if (n == 16) begin
                checks++; if (full_m !== 1'b0) begin errors++; $display("FAIL fill_full_after_16 got %b want 0", full_m); end
            end
            if (n == 17) begin
                checks++; if (full_m !== 1'b1) begin errors++; $display("FAIL fill_full_after_17 got %b want 1", full_m); end
                checks++; if (level_m !== 5'd16) begin errors++; $display("FAIL fill_level_after_17 got %0d want 16", level_m); end
                checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL fill_overflow_after_17 got %b want 0", ovf_m); end
            end
            if (n == 18) begin
                checks++; if (ovf_m !== 1'b1) begin errors++; $display("FAIL fill_overflow_after_18 got %b want 1", ovf_m); end
                checks++; if (level_m !== 5'd16) begin errors++; $display("FAIL fill_level_after_18 got %0d want 16", level_m); end
            end
        end
        checks++; if (empty_m !== 1'b1) begin errors++; $display("FAIL fill_final_empty got %b want 1", empty_m); end
        checks++; if (busy_m !== 1'b0)  begin errors++; $display("FAIL fill_final_busy got %b want 0", busy_m); end
        checks++; if (ovf_m !== 1'b1)   begin errors++; $display("FAIL fill_final_overflow got %b want 1", ovf_m); end
        checks++; if (level_m !== 5'd0) begin errors++; $display("FAIL fill_final_level got %0d want 0", level_m); end
        $display("test_fill_overflow done: 17 frames 00..10 checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid_frame();
        sel = 0;
        @(negedge clk);
        wr_v = 1'b1; data_v = 8'h00;
        for (int n = 1; n <= 19; n++) begin
            @(negedge clk);
            wr_v = (n < 4);
            data_v = 8'hAA;
        end
        // Cycle 19 sits inside data bit 3 of the first (all-zero) word.
        checks++; if (line_m !== 1'b0)   begin errors++; $display("FAIL midframe_line_before got %b want 0", line_m); end
        checks++; if (busy_m !== 1'b1)   begin errors++; $display("FAIL midframe_busy_before got %b want 1", busy_m); end
        checks++; if (level_m !== 5'd3)  begin errors++; $display("FAIL midframe_level_before got %0d want 3", level_m); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (line_m !== 1'b1)   begin errors++; $display("FAIL midframe_line_async got %b want 1", line_m); end
        checks++; if (busy_m !== 1'b0)   begin errors++; $display("FAIL midframe_busy_async got %b want 0", busy_m); end
        checks++; if (level_m !== 5'd0)  begin errors++; $display("FAIL midframe_level_async got %0d want 0", level_m); end
        checks++; if (empty_m !== 1'b1)  begin errors++; $display("FAIL midframe_empty_async got %b want 1", empty_m); end
        checks++; if (ovf_m !== 1'b0)    begin errors++; $display("FAIL midframe_overflow_async got %b want 0", ovf_m); end
        wr_v = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (level_m !== 5'd0)  begin errors++; $display("FAIL midframe_wr_during_rst got level %0d want 0", level_m); end
        wr_v = 1'b0;
        rst = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            checks++; if (line_m !== 1'b1) begin errors++; $display("FAIL post_reset_line cycle %0d got %b want 1", n, line_m); end
            checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL post_reset_busy cycle %0d got %b want 0", n, busy_m); end
        end
        checks++; if (empty_m !== 1'b1) begin errors++; $display("FAIL post_reset_empty got %b want 1", empty_m); end
        $display("test_reset_mid_frame done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity();
        test_narrow();
        test_back_to_back();
        test_fill_overflow();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
